snpu_legislative_sequencer: RTL
===============================

// Module: snpu_legislative_sequencer
// PURPOSE
//  Host-side initiator for the SNPU policy engine. Turns player selections into the policy-op command stream (shuffle, display, discard, play, board readout).
//  Sits between the player I/O and the policy unit; the policy unit is the responder.
//  Runs one legislative session per session_start. Mirrors the stack count, detects the reshuffle point and the game-over condition.
// PARAMETERS
//  SHUFFLE_PASSES  4   OP_shuffle commands issued per reshuffle (1..15)
//  WIN_ONES        5   board ones count that ends the game, winner=1
//  WIN_ZEROS       6   board zeros count that ends the game, winner=0
//  DECK_SIZE       17  total policy cards; stack mirror reload base
// PORTS
//  clk            in   1  clock
//  rst_n          in   1  asynchronous active-low reset
//  new_game       in   1  pulse: issue OP_reset, clear board/game_over, stack_cnt=DECK_SIZE
//  session_start  in   1  pulse: begin legislative session
//  sel_valid      in   1  pulse: player selection present
//  sel_idx        in   2  selected hand index
//  cmd_valid      out  1  command valid to policy unit
//  cmd_ready      in   1  policy unit accepts command
//  cmd_op         out  3  0 reset,1 player_reset,2 player_get,3 shuffle,4 hand_display,5 hand_discard,6 hand_play,7 board_display
//  cmd_arg        out  5  command index argument
//  rsp_valid      in   1  one-cycle response strobe
//  rsp_data       in   8  response; display: bit0=card; board: [7:4]=ones,[3:0]=zeros
//  hand_cards     out  3  displayed cards, bit i = hand index i
//  pres_turn      out  1  waiting for president selection (3 cards)
//  chan_turn      out  1  waiting for chancellor selection (2 cards)
//  board_ones     out  4  last board readout, ones
//  board_zeros    out  4  last board readout, zeros
//  stack_cnt      out  5  mirrored stack count
//  busy           out  1  session or new_game in progress
//  sel_err        out  1  one-cycle pulse: out-of-range or unexpected selection
//  game_over      out  1  sticky until new_game or reset
//  winner         out  1  valid when game_over
// BEHAVIOUR
//  Reset: all outputs 0 except stack_cnt=DECK_SIZE; FSM=IDLE.
//  Handshake: cmd_valid/cmd_op/cmd_arg held stable until cmd_valid&cmd_ready. Exactly one command outstanding.
//  Handshake: the next command issues no earlier than the cycle after rsp_valid. rsp_valid outside WAIT_RSP is ignored.
//  FSM: IDLE -> [SHUF xN] -> DISP(0,1,2) -> WAIT_PRES -> DISC -> DISP(0,1) -> WAIT_CHAN -> PLAY -> BOARD -> IDLE.
//  SHUF is entered only if stack_cnt<3. After the last pass: stack_cnt = DECK_SIZE - board_ones - board_zeros.
//  DISP(k): op 4, arg k; rsp_data[0] -> hand_cards[k]. Entering DISP(0,1) clears hand_cards[2].
//  WAIT_PRES: pres_turn=1. sel_valid with sel_idx<=2 -> DISC, op 5, arg sel_idx.
//  WAIT_CHAN: chan_turn=1. sel_valid with sel_idx<=1 -> PLAY, op 6, arg sel_idx.
//  Out-of-range index in WAIT_PRES/WAIT_CHAN -> sel_err pulse; the state is held.
//  sel_valid in any other state -> sel_err pulse; otherwise ignored.
//  BOARD: op 7, arg 0; latch board_ones/zeros; stack_cnt -= 3 (saturates at 0).
//  Game end: game_over=1, winner=1 if ones>=WIN_ONES, else winner=0 if zeros>=WIN_ZEROS. Ones is checked first.
//  Game end: while game_over, session_start is ignored.
//  session_start while busy: ignored. new_game while busy: latched, serviced on return to IDLE.
//  new_game: op 0 then IDLE. Simultaneous with session_start in IDLE: new_game wins, start dropped.
//  Reset mid-command: cmd_valid drops asynchronously. No partial state is kept.
//  pres_turn/chan_turn are registered and deassert the cycle after the accepted selection.
// STRUCTURE
//  Shared package snpu_pkg: op-code localparams OP_RESET..OP_BOARD_DISPLAY; FSM state enum; DECK_SIZE default.
//  Sub-module snpu_cmd_port: issue/hold/wait-rsp handshake with req/done to the FSM.
//  Sequencer FSM, stack mirror, shuffle pass counter and win logic stay in the top module.
// TESTING
//  Reset -> stack_cnt=17, cmd_valid=0, game_over=0, pres_turn=chan_turn=0, busy=0.
//  Session, responder cards 1,0,1, pres sel 1, cards 1,1, chan sel 0, board 0x10 -> ops 4/0,4/1,4/2,5/1,4/0,4/1,6/0,7/0.
//   Same session cont.: hand_cards seen 101 then 011; board_ones=1; stack_cnt=14.
//  Backpressure: cmd_ready low 4 cycles -> cmd_valid, op, arg stable all cycles; exactly one issue.
//  Six sessions, 5 boards -> sixth starts with SHUFFLE_PASSES op-3 commands; then stack_cnt=12 (17-5).
//  sel_idx=3 in WAIT_PRES -> sel_err pulse, still WAIT_PRES. sel in IDLE -> sel_err, no command.
//  Board rsp 0x50 -> game_over=1, winner=1; next session_start issues nothing. new_game -> op 0, game_over=0.

Source files
------------

// File: rtl/snpu_pkg.sv
// SNPU shared definitions: policy-unit op codes and sequencer states.
// Imported by the legislative sequencer and its command port.
package snpu_pkg;

    localparam logic [2:0] OP_RESET         = 3'd0;
    localparam logic [2:0] OP_PLAYER_RESET  = 3'd1;
    localparam logic [2:0] OP_PLAYER_GET    = 3'd2;
    localparam logic [2:0] OP_SHUFFLE       = 3'd3;
    localparam logic [2:0] OP_HAND_DISPLAY  = 3'd4;
    localparam logic [2:0] OP_HAND_DISCARD  = 3'd5;
    localparam logic [2:0] OP_HAND_PLAY     = 3'd6;
    localparam logic [2:0] OP_BOARD_DISPLAY = 3'd7;

    localparam int DECK_SIZE_DEFAULT = 17;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_NEWG,
        ST_SHUF,
        ST_DISP3,
        ST_WAIT_PRES,
        ST_DISC,
        ST_DISP2,
        ST_WAIT_CHAN,
        ST_PLAY,
        ST_BOARD
    } state_t;

endpackage

// File: rtl/snpu_cmd_port.sv
// Command port toward the policy unit: issue, hold under backpressure,
// then wait for the single response before accepting the next request.
module snpu_cmd_port (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [2:0] req_op,
    input  logic [4:0] req_arg,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_op,
    output logic [4:0] cmd_arg,
    input  logic       rsp_valid,
    input  logic [7:0] rsp_data,
    output logic       done,
    output logic [7:0] data
);

    logic waiting;

    // Responses arriving while not waiting are simply not seen.
    assign done = waiting & rsp_valid;
    assign data = rsp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd_op    <= 3'd0;
            cmd_arg   <= 5'd0;
            waiting   <= 1'b0;
        end else if (cmd_valid) begin
            if (cmd_ready) begin
                cmd_valid <= 1'b0;
                waiting   <= 1'b1;
            end
        end else if (waiting) begin
            if (rsp_valid) begin
                waiting <= 1'b0;
            end
        end else if (req) begin
            cmd_valid <= 1'b1;
            cmd_op    <= req_op;
            cmd_arg   <= req_arg;
        end
    end

endmodule

// File: rtl/snpu_legislative_sequencer.sv
// Legislative session sequencer: drives the policy unit through one
// session per start, mirroring stack count, board state and game end.
module snpu_legislative_sequencer
    import snpu_pkg::*;
#(
    parameter int SHUFFLE_PASSES = 4,
    parameter int WIN_ONES       = 5,
    parameter int WIN_ZEROS      = 6,
    parameter int DECK_SIZE      = DECK_SIZE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       session_start,
    input  logic       sel_valid,
    input  logic [1:0] sel_idx,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_op,
    output logic [4:0] cmd_arg,
    input  logic       rsp_valid,
    input  logic [7:0] rsp_data,
    output logic [2:0] hand_cards,
    output logic       pres_turn,
    output logic       chan_turn,
    output logic [3:0] board_ones,
    output logic [3:0] board_zeros,
    output logic [4:0] stack_cnt,
    output logic       busy,
    output logic       sel_err,
    output logic       game_over,
    output logic       winner
);

    localparam logic [4:0] DECK5   = 5'(DECK_SIZE);
    localparam logic [3:0] PASSES4 = 4'(SHUFFLE_PASSES);
    localparam logic [3:0] WIN1    = 4'(WIN_ONES);
    localparam logic [3:0] WIN0    = 4'(WIN_ZEROS);

    state_t     state;
    logic       req;
    logic [2:0] req_op;
    logic [4:0] req_arg;
    logic       done;
    logic [7:0] data;
    logic [3:0] pass_cnt;
    logic [1:0] disp_k;
    logic       ng_pend;
    logic [4:0] refill;
    logic [2:0] card_mask;
    logic [2:0] card_bit;

    assign refill    = DECK5 - {1'b0, board_ones} - {1'b0, board_zeros};
    assign card_mask = ~(3'b001 << disp_k);
    assign card_bit  = {2'b00, data[0]} << disp_k;
    assign busy      = (state != ST_IDLE);

    snpu_cmd_port u_port (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_op    (req_op),
        .req_arg   (req_arg),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .done      (done),
        .data      (data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            req         <= 1'b0;
            req_op      <= OP_RESET;
            req_arg     <= 5'd0;
            pass_cnt    <= 4'd0;
            disp_k      <= 2'd0;
            ng_pend     <= 1'b0;
            hand_cards  <= 3'd0;
            pres_turn   <= 1'b0;
            chan_turn   <= 1'b0;
            board_ones  <= 4'd0;
            board_zeros <= 4'd0;
            stack_cnt   <= DECK5;
            sel_err     <= 1'b0;
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else begin
            req     <= 1'b0;
            sel_err <= 1'b0;
            if (new_game && state != ST_IDLE) begin
                ng_pend <= 1'b1;
            end
            if (sel_valid && state != ST_WAIT_PRES && state != ST_WAIT_CHAN) begin
                sel_err <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    // A pending or fresh new_game takes priority over a start.
                    if (new_game || ng_pend) begin
                        ng_pend <= 1'b0;
                        req     <= 1'b1;
                        req_op  <= OP_RESET;
                        req_arg <= 5'd0;
                        state   <= ST_NEWG;
                    end else if (session_start && !game_over) begin
                        req     <= 1'b1;
                        req_arg <= 5'd0;
                        if (stack_cnt < 5'd3) begin
                            pass_cnt <= 4'd1;
                            req_op   <= OP_SHUFFLE;
                            state    <= ST_SHUF;
                        end else begin
                            disp_k <= 2'd0;
                            req_op <= OP_HAND_DISPLAY;
                            state  <= ST_DISP3;
                        end
                    end
                end
                ST_NEWG: begin
                    if (done) begin
                        board_ones  <= 4'd0;
                        board_zeros <= 4'd0;
                        game_over   <= 1'b0;
                        winner      <= 1'b0;
                        stack_cnt   <= DECK5;
                        state       <= ST_IDLE;
                    end
                end
                ST_SHUF: begin
                    if (done) begin
                        req     <= 1'b1;
                        req_arg <= 5'd0;
                        if (pass_cnt == PASSES4) begin
                            stack_cnt <= refill;
                            disp_k    <= 2'd0;
                            req_op    <= OP_HAND_DISPLAY;
                            state     <= ST_DISP3;
                        end else begin
                            pass_cnt <= pass_cnt + 4'd1;
                            req_op   <= OP_SHUFFLE;
                        end
                    end
                end
                ST_DISP3: begin
                    if (done) begin
                        hand_cards <= (hand_cards & card_mask) | card_bit;
                        if (disp_k == 2'd2) begin
                            pres_turn <= 1'b1;
                            state     <= ST_WAIT_PRES;
                        end else begin
                            disp_k  <= disp_k + 2'd1;
                            req     <= 1'b1;
                            req_op  <= OP_HAND_DISPLAY;
                            req_arg <= {3'd0, disp_k + 2'd1};
                        end
                    end
                end
                ST_WAIT_PRES: begin
                    if (sel_valid) begin
                        if (sel_idx != 2'd3) begin
                            pres_turn <= 1'b0;
                            req       <= 1'b1;
                            req_op    <= OP_HAND_DISCARD;
                            req_arg   <= {3'd0, sel_idx};
                            state     <= ST_DISC;
                        end else begin
                            sel_err <= 1'b1;
                        end
                    end
                end
                ST_DISC: begin
                    if (done) begin
                        hand_cards <= hand_cards & 3'b011;
                        disp_k     <= 2'd0;
                        req        <= 1'b1;
                        req_op     <= OP_HAND_DISPLAY;
                        req_arg    <= 5'd0;
                        state      <= ST_DISP2;
                    end
                end
                ST_DISP2: begin
                    if (done) begin
                        hand_cards <= (hand_cards & card_mask) | card_bit;
                        if (disp_k == 2'd1) begin
                            chan_turn <= 1'b1;
                            state     <= ST_WAIT_CHAN;
                        end else begin
                            disp_k  <= 2'd1;
                            req     <= 1'b1;
                            req_op  <= OP_HAND_DISPLAY;
                            req_arg <= 5'd1;
                        end
                    end
                end
                ST_WAIT_CHAN: begin
                    if (sel_valid) begin
                        if (!sel_idx[1]) begin
                            chan_turn <= 1'b0;
                            req       <= 1'b1;
                            req_op    <= OP_HAND_PLAY;
                            req_arg   <= {3'd0, sel_idx};
                            state     <= ST_PLAY;
                        end else begin
                            sel_err <= 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (done) begin
                        req     <= 1'b1;
                        req_op  <= OP_BOARD_DISPLAY;
                        req_arg <= 5'd0;
                        state   <= ST_BOARD;
                    end
                end
                ST_BOARD: begin
                    if (done) begin
                        board_ones  <= data[7:4];
                        board_zeros <= data[3:0];
                        stack_cnt   <= (stack_cnt < 5'd3) ? 5'd0 : stack_cnt - 5'd3;
                        // Ones win is checked before zeros.
                        if (data[7:4] >= WIN1) begin
                            game_over <= 1'b1;
                            winner    <= 1'b1;
                        end else if (data[3:0] >= WIN0) begin
                            game_over <= 1'b1;
                            winner    <= 1'b0;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
